seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
// PURPOSE
//  Time-multiplexed driver for an N-digit 7-segment display (segments + decimal point).
//  Scans one digit per slot, with a configurable blanking gap between slots to suppress ghosting.
//  Per-digit masking, a frame-start strobe and optional PWM dimming are included.
//  Sits between the digit-pattern encoders and the board pins; successor to the fixed 4-digit scanner.
// PARAMETERS
//  N_DIGITS      4    number of digits scanned (2..16)
//  DIV           1    clk10 cycles per scan tick (>=1); DIV=1 -> tick every cycle
//  DWELL         4    ticks per digit slot (>=2)
//  BLANK_TICKS   1    leading ticks of each slot with the digit off (0..DWELL-1)
//  SEG_ACT_LOW   0    1: seg/dp driven active-low
//  EN_ACT_LOW    1    1: segen driven active-low (one-cold select)
//  BRW           4    brightness width (used only with SEG_SCAN_DIM_EN)
// PORTS
//  clk10        in   1            scan clock
//  rst_n        in   1            async active-low reset
//  seg_in       in   7*N_DIGITS   digit k pattern at [7k+6:7k], bit0=segment a
//  dp_in        in   N_DIGITS     decimal point per digit
//  digit_mask   in   N_DIGITS     1 = digit shown, 0 = digit kept dark
//  brightness   in   BRW          PWM duty (port present only with SEG_SCAN_DIM_EN)
//  seg          out  7            segment drive, polarity per SEG_ACT_LOW
//  dp           out  1            decimal point drive
//  segen        out  N_DIGITS     digit enables, polarity per EN_ACT_LOW
//  frame_start  out  1            1-cycle pulse when digit 0 slot begins
// BEHAVIOUR
//  - Reset (async assert, sync release): prescaler=0, slot tick cnt=0, digit idx=0, state BLANK;
//    seg/dp/segen at inactive level (all bits off per polarity); frame_start=0.
//  - Prescaler counts 0..DIV-1, emits tick on DIV-1 then wraps to 0.
//  - FSM states: BLANK, SHOW. Slot = DWELL ticks. First BLANK_TICKS ticks in BLANK, rest in SHOW.
//    BLANK_TICKS=0 -> slot begins directly in SHOW.
//  - At slot start (last tick of previous slot), seg_in/dp_in/digit_mask for the new idx are
//    latched into a snapshot. Input changes mid-slot never alter the displayed digit.
//  - Registered outputs: new slot visible on the cycle after the boundary tick.
//  - BLANK: segen all inactive, seg/dp inactive.
//  - SHOW: seg/dp = snapshot; segen bit idx active, others inactive.
//    If snapshot mask bit=0, behave as BLANK for the whole slot. Masked slots still consume time.
//  - idx wraps N_DIGITS-1 -> 0. frame_start pulses with the first output cycle of slot 0,
//    including the first slot after reset release.
//  - Never more than one segen bit active in any cycle, including during reset and wrap.
//  - digit_mask all 0: outputs permanently inactive, frame_start still pulses every frame.
// CONFIGURATION
//  SEG_SCAN_DIM_EN defined:
//    - Free-running BRW-bit PWM counter on clk10, reset to 0.
//    - In SHOW, segen asserted only while pwm_cnt < brightness. brightness=0 -> dark.
//    - seg/dp still driven per snapshot.
//  SEG_SCAN_DIM_EN undefined: no brightness port, no PWM logic, full duty in SHOW.
// STRUCTURE
//  - Package seg_scan_pkg: typedef enum {ST_BLANK, ST_SHOW} scan_state_t; SEG_W=7 constant;
//    function polarity(val, act_low).
//  - Sub-module scan_prescaler (DIV param, tick output). Remainder stays in one module.
// TESTING  (N_DIGITS=4, DIV=2, DWELL=4, BLANK_TICKS=1, EN_ACT_LOW=1, SEG_ACT_LOW=0)
//  1 Reset release, seg_in={7'h06,7'h5B,7'h4F,7'h66}, mask=4'hF:
//    - segen=4'b1111 for 2 cycles, then 4'b1110 with seg=7'h66 for 6 cycles.
//    - Digits 1,2,3 follow; frame_start pulses every 32 cycles.
//  2 mask=4'b1010:
//    - Slots 0 and 2 show segen=4'b1111, seg=0.
//    - Slot timing unchanged: frame period stays 32 cycles.
//  3 Change seg_in[6:0] mid-slot 0: displayed value unchanged until slot 0 of next frame.
//  4 Assert rst_n=0 mid-SHOW: outputs go inactive the same cycle, no clock edge needed.
//    On release, scan restarts at digit 0.
//  5 Assertion check, every cycle: $countones(~segen)<=1.
//    Also every cycle: segen==4'b1111 whenever state==BLANK.
//  6 SEG_SCAN_DIM_EN, BRW=4:
//    - brightness=4 -> segen active 4 of every 16 SHOW cycles.
//    - brightness=0 -> always inactive.
//    - brightness=15 -> active 15 of 16 SHOW cycles.

Source files
------------

// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_pkg
//  Description : Shared types, constants and helpers for the 7-segment
//                scan multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

    // Per-slot display state: leading blanking gap, then digit shown
    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Segments a..g per digit (decimal point carried separately)
    localparam int SEG_W = 7;

    // Map a logical "on" bit onto the pin level for the given drive polarity
    function automatic logic polarity(input logic val, input logic act_low);
        return val ^ act_low;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : scan_prescaler
//  Description : Divides the scan clock into a one-cycle tick every DIV
//                cycles. clr_i restarts the count so the first tick after a
//                restart lands a full DIV cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk10,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    generate
        if (DIV == 1) begin : g_div_one
            // Every cycle is a tick; no counter needed
            logic w_unused;
            assign w_unused = ^{clk10, rst_n, clr_i};
            assign tick_o   = 1'b1;
        end else begin : g_div_n
            localparam int CW = $clog2(DIV);
            localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

            logic [CW-1:0] cnt_q;

            // Count 0..DIV-1 and wrap; a restart forces the count back to 0
            always_ff @(posedge clk10 or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (clr_i || (cnt_q == C_LAST)) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign tick_o = (cnt_q == C_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_mux
//  Description : Time-multiplexed N-digit 7-segment driver. Each digit owns a
//                slot of DWELL scan ticks; the first BLANK_TICKS ticks keep all
//                digits dark to suppress ghosting. Inputs for a slot are
//                snapshotted at the slot boundary, outputs are registered and
//                frame_start marks the first output cycle of digit 0.
//                Optional PWM dimming is enabled by defining SEG_SCAN_DIM_EN,
//                which adds the brightness port.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int DIV         = 1,
    parameter int DWELL       = 4,
    parameter int BLANK_TICKS = 1,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit EN_ACT_LOW  = 1'b1,
    parameter int BRW         = 4
) (
    input  logic                      clk10,
    input  logic                      rst_n,
    input  logic [SEG_W*N_DIGITS-1:0] seg_in,
    input  logic [N_DIGITS-1:0]       dp_in,
    input  logic [N_DIGITS-1:0]       digit_mask,
`ifdef SEG_SCAN_DIM_EN
    input  logic [BRW-1:0]            brightness,
`endif
    output logic [SEG_W-1:0]          seg,
    output logic                      dp,
    output logic [N_DIGITS-1:0]       segen,
    output logic                      frame_start
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int TC_W  = $clog2(DWELL);

    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [TC_W-1:0]  C_TC_LAST  = TC_W'(DWELL - 1);
    localparam logic [TC_W-1:0]  C_TC_SHOW  = TC_W'(BLANK_TICKS);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // init_q marks the first cycle after reset release: it is treated as
    // the boundary tick of a virtual previous slot, so slot 0 gets a proper
    // input snapshot and a frame_start pulse just like every later frame.
    logic                init_q;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic [TC_W-1:0]     tc_q,        tc_d;
    scan_state_t         state_q,     state_d;
    logic [SEG_W-1:0]    snap_seg_q,  snap_seg_d;
    logic                snap_dp_q,   snap_dp_d;
    logic                snap_mask_q, snap_mask_d;
    logic [SEG_W-1:0]    seg_q,       seg_d;
    logic                dp_q,        dp_d;
    logic [N_DIGITS-1:0] segen_q,     segen_d;
    logic                fs_q,        fs_d;

    logic w_tick;
    logic w_slot_end;
    logic w_show;
    logic w_en_on;

    scan_prescaler #(
        .DIV    (DIV)
    ) u_prescaler (
        .clk10  (clk10),
        .rst_n  (rst_n),
        .clr_i  (init_q),
        .tick_o (w_tick)
    );

`ifdef SEG_SCAN_DIM_EN
    logic [BRW-1:0] pwm_q, pwm_d;

    // Free-running PWM phase counter
    always_ff @(posedge clk10 or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    // Duty compare uses the phase the output register will hold next cycle
    always_comb begin
        pwm_d   = pwm_q + 1'b1;
        w_en_on = (pwm_d < brightness);
    end
`else
    localparam int c_brw_unused = BRW;
    assign w_en_on = 1'b1;
`endif

    assign w_slot_end = init_q || (w_tick && (tc_q == C_TC_LAST));

    // Next slot position, snapshot and output levels (outputs track state_d
    // so the registered pins and the registered state always agree)
    always_comb begin
        idx_d       = idx_q;
        tc_d        = tc_q;
        state_d     = state_q;
        snap_seg_d  = snap_seg_q;
        snap_dp_d   = snap_dp_q;
        snap_mask_d = snap_mask_q;
        fs_d        = 1'b0;
        seg_d       = '0;
        segen_d     = '0;
        dp_d        = 1'b0;
        w_show      = 1'b0;

        if (w_slot_end) begin
            idx_d       = (init_q || (idx_q == C_IDX_LAST)) ? '0 : idx_q + 1'b1;
            tc_d        = '0;
            state_d     = (BLANK_TICKS == 0) ? ST_SHOW : ST_BLANK;
            snap_seg_d  = seg_in[int'(idx_d)*SEG_W +: SEG_W];
            snap_dp_d   = dp_in[idx_d];
            snap_mask_d = digit_mask[idx_d];
            fs_d        = (idx_d == '0);
        end else if (w_tick) begin
            tc_d    = tc_q + 1'b1;
            state_d = (tc_d >= C_TC_SHOW) ? ST_SHOW : ST_BLANK;
        end

        // A masked digit stays dark for its whole slot but still uses the time
        w_show = (state_d == ST_SHOW) && snap_mask_d;

        for (int b = 0; b < SEG_W; b++) begin
            seg_d[b] = polarity(w_show && snap_seg_d[b], SEG_ACT_LOW);
        end
        dp_d = polarity(w_show && snap_dp_d, SEG_ACT_LOW);

        // At most one enable can be on since only idx_d can match
        for (int k = 0; k < N_DIGITS; k++) begin
            segen_d[k] = polarity(w_show && w_en_on && (idx_d == IDX_W'(k)), EN_ACT_LOW);
        end
    end

    // Scan FSM, snapshot and registered pin drivers
    always_ff @(posedge clk10 or negedge rst_n) begin
        if (!rst_n) begin
            init_q      <= 1'b1;
            idx_q       <= '0;
            tc_q        <= '0;
            state_q     <= ST_BLANK;
            snap_seg_q  <= '0;
            snap_dp_q   <= 1'b0;
            snap_mask_q <= 1'b0;
            seg_q       <= {SEG_W{SEG_ACT_LOW}};
            dp_q        <= SEG_ACT_LOW;
            segen_q     <= {N_DIGITS{EN_ACT_LOW}};
            fs_q        <= 1'b0;
        end else begin
            init_q      <= 1'b0;
            idx_q       <= idx_d;
            tc_q        <= tc_d;
            state_q     <= state_d;
            snap_seg_q  <= snap_seg_d;
            snap_dp_q   <= snap_dp_d;
            snap_mask_q <= snap_mask_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            segen_q     <= segen_d;
            fs_q        <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign segen       = segen_q;
    assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_mux
//  Description : Self-checking bench for seg_scan_mux (4 digits, DIV=2,
//                DWELL=4, BLANK_TICKS=1, one-cold enables). k counts clock
//                edges after reset release; slot s of a frame spans edges
//                8s+1..8s+8 with the first two cycles blank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_mux;
    import seg_scan_pkg::*;

    logic        clk10 = 1'b0;
    logic        rst_n;
    logic [27:0] seg_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_mask;
`ifdef SEG_SCAN_DIM_EN
    logic [3:0]  brightness;
`endif
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  segen;
    logic        frame_start;

    int errors = 0;
    int checks = 0;
    int k      = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [3:0] segen;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } vec_t;

    vec_t tbl[13];

    seg_scan_mux #(
        .N_DIGITS    (4),
        .DIV         (2),
        .DWELL       (4),
        .BLANK_TICKS (1),
        .SEG_ACT_LOW (1'b0),
        .EN_ACT_LOW  (1'b1),
        .BRW         (4)
    ) dut (
        .clk10       (clk10),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .digit_mask  (digit_mask),
`ifdef SEG_SCAN_DIM_EN
        .brightness  (brightness),
`endif
        .seg         (seg),
        .dp          (dp),
        .segen       (segen),
        .frame_start (frame_start)
    );

    always #5 clk10 = ~clk10;

    task automatic step();
        @(posedge clk10);
        #1;
        k++;
    endtask

    task automatic chk(input string name, input logic [3:0] es, input logic [6:0] eseg,
                       input logic edp, input logic efs);
        checks++;
        if (segen !== es || seg !== eseg || dp !== edp || frame_start !== efs) begin
            errors++;
            $display("FAIL %s k=%0d: got segen=%b seg=%h dp=%b fs=%b, want segen=%b seg=%h dp=%b fs=%b",
                     name, k, segen, seg, dp, frame_start, es, eseg, edp, efs);
        end
    endtask

    task automatic release_reset();
        @(negedge clk10);
        rst_n = 1'b1;
        k = 0;
    endtask

    // Every cycle: one-cold enables, and no enable while the FSM is blanking
    always @(posedge clk10) begin
        #1;
        if (mon_en) begin
            checks++;
            if ($countones(~segen) > 1 || (dut.state_q == ST_BLANK && segen != 4'hF)) begin
                errors++;
                $display("FAIL onecold k=%0d: segen=%b state=%0d", k, segen, dut.state_q);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

`ifdef SEG_SCAN_DIM_EN
    int bl[3] = '{4, 0, 15};
`endif

    initial begin
        tbl[0]  = '{1,  4'hF, 7'h00, 1'b0, 1'b1};
        tbl[1]  = '{2,  4'hF, 7'h00, 1'b0, 1'b0};
        tbl[2]  = '{3,  4'hE, 7'h66, 1'b1, 1'b0};
        tbl[3]  = '{8,  4'hE, 7'h66, 1'b1, 1'b0};
        tbl[4]  = '{9,  4'hF, 7'h00, 1'b0, 1'b0};
        tbl[5]  = '{10, 4'hF, 7'h00, 1'b0, 1'b0};
        tbl[6]  = '{11, 4'hD, 7'h4F, 1'b0, 1'b0};
        tbl[7]  = '{16, 4'hD, 7'h4F, 1'b0, 1'b0};
        tbl[8]  = '{19, 4'hB, 7'h5B, 1'b1, 1'b0};
        tbl[9]  = '{27, 4'h7, 7'h06, 1'b0, 1'b0};
        tbl[10] = '{32, 4'h7, 7'h06, 1'b0, 1'b0};
        tbl[11] = '{33, 4'hF, 7'h00, 1'b0, 1'b1};
        tbl[12] = '{35, 4'hE, 7'h66, 1'b1, 1'b0};

        rst_n      = 1'b0;
        seg_in     = {7'h06, 7'h5B, 7'h4F, 7'h66};
        dp_in      = 4'b0101;
        digit_mask = 4'hF;
`ifdef SEG_SCAN_DIM_EN
        brightness = 4'd0;
`endif
        mon_en     = 1'b1;
        repeat (3) @(posedge clk10);
        #1;
        chk("reset_state", 4'hF, 7'h00, 1'b0, 1'b0);

`ifdef SEG_SCAN_DIM_EN
        // PWM dimming: enable only in SHOW cycles whose PWM phase (k mod 16)
        // is below the brightness value
        for (int t = 0; t < 3; t++) begin
            rst_n = 1'b0;
            brightness = bl[t][3:0];
            repeat (2) @(posedge clk10);
            release_reset();
            for (int c = 1; c <= 32; c++) begin
                int         p;
                int         d;
                logic [3:0] es;
                step();
                p  = (c - 1) % 8;
                d  = ((c - 1) / 8) % 4;
                es = 4'hF;
                if (p >= 2 && (c % 16) < bl[t]) es[d] = 1'b0;
                checks++;
                if (segen !== es) begin
                    errors++;
                    $display("FAIL dim_b%0d k=%0d: got segen=%b want %b", bl[t], c, segen, es);
                end
            end
        end
`else
        release_reset();

        // Basic scan sequence after reset release
        for (int i = 0; i < 13; i++) begin
            while (k < tbl[i].cyc) step();
            chk($sformatf("scan_vec%0d", i), tbl[i].segen, tbl[i].seg, tbl[i].dp, tbl[i].fs);
        end

        // Mid-slot input change is held off until the next frame's slot 0
        while (k < 36) step();
        seg_in[6:0] = 7'h7F;
        step();
        chk("hold_k37", 4'hE, 7'h66, 1'b1, 1'b0);
        while (k < 40) step();
        chk("hold_k40", 4'hE, 7'h66, 1'b1, 1'b0);
        while (k < 65) step();
        chk("frame2_start", 4'hF, 7'h00, 1'b0, 1'b1);
        while (k < 67) step();
        chk("new_value", 4'hE, 7'h7F, 1'b1, 1'b0);

        // Masked digits stay dark without changing slot timing
        digit_mask = 4'b1010;
        while (k < 99) step();
        chk("mask_slot0", 4'hF, 7'h00, 1'b0, 1'b0);
        while (k < 107) step();
        chk("mask_slot1", 4'hD, 7'h4F, 1'b0, 1'b0);
        while (k < 115) step();
        chk("mask_slot2", 4'hF, 7'h00, 1'b0, 1'b0);
        while (k < 128) step();
        chk("mask_slot3", 4'h7, 7'h06, 1'b0, 1'b0);
        step();
        chk("mask_frame", 4'hF, 7'h00, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a SHOW window
        digit_mask = 4'hF;
        while (k < 139) step();
        chk("pre_rst_show", 4'hD, 7'h4F, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 4'hF, 7'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk10);
        release_reset();
        step();
        chk("restart_k1", 4'hF, 7'h00, 1'b0, 1'b1);
        while (k < 3) step();
        chk("restart_k3", 4'hE, 7'h7F, 1'b1, 1'b0);
`endif

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
